vga_frame_scanner: RTL and testbench
====================================

Name: vga_frame_scanner

Overview:
- Parametrised successor to the fixed-geometry VGA scanner.
- Generates fully configurable VGA timing and places a scaled image window inside the active area.
- Issues SRAM pixel read requests with window-relative addresses, absorbs a configurable SRAM read latency, and emits a pipeline-aligned RGB pixel stream with HS/VS/DE.
- Sits between the top-level state machine and the SRAM read port and drives the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
- W, 320, image width in source pixels
- H, 240, image height in source lines
- STARTCOL, 0, window left edge in active-area pixels
- STARTROW, 0, window top edge in active-area lines
- SCALE_LOG2, 0, pixel/line replication factor = 2^SCALE_LOG2 (0..2)
- RD_LAT, 2, SRAM read latency in clocks (1..4)
- PIX_W, 16, pixel width
- CW, 12, counter/address width
- RUN_STATE, 8'h03, i_state value that enables scanning
- BG_COLOR, 0, o_rgb value inside the active area but outside the window

Ports:
- i_clk_sys  in  1  system/pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_state  in  8  top-level state; scanning runs only while i_state == RUN_STATE
- o_hcnt  out  CW  raw horizontal counter
- o_vcnt  out  CW  raw vertical counter
- o_rd_req  out  1  SRAM read strobe (spram_rd_sig)
- o_xpos  out  CW  source x address
- o_ypos  out  CW  source y address
- i_rd_data  in  PIX_W  SRAM data, valid RD_LAT clocks after o_rd_req
- o_frame_start  out  1  one-clock pulse at the start of each frame
- o_hs  out  1  VGA horizontal sync
- o_vs  out  1  VGA vertical sync
- o_de  out  1  active-video enable
- o_rgb  out  PIX_W  pixel output

Behaviour:
- Clocking and reset: one clock, i_clk_sys; i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0, except o_hs and o_vs, which go to the inactive level (~SYNC_POL).
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise.
- Segment order per line and frame: active, front porch, sync, back porch.
- Counters (cycle t):
  - hcnt counts 0..H_TOT-1, then wraps to 0 and increments vcnt.
  - vcnt counts 0..V_TOT-1, then wraps to 0.
  - Both advance only while i_state == RUN_STATE.
- Leaving RUN_STATE (any point, including mid-line): next clock counters clear to 0; o_rd_req, o_de and o_frame_start go to 0; o_rgb goes to 0; syncs go inactive. The pipeline is flushed, with no stale pixels.
- Re-entering RUN_STATE: scanning restarts from (0,0).
- Stage 1 (t+1, registered): o_hcnt/o_vcnt show (h,v).
  - o_rd_req = 1 iff STARTCOL <= h < STARTCOL+(W<<SCALE_LOG2) and STARTROW <= v < STARTROW+(H<<SCALE_LOG2).
  - While o_rd_req = 1: o_xpos = (h-STARTCOL)>>SCALE_LOG2 and o_ypos = (v-STARTROW)>>SCALE_LOG2.
  - Otherwise o_xpos/o_ypos hold 0.
  - o_frame_start = 1 iff (h,v) = (0,0).
- Data capture: i_rd_data is sampled exactly RD_LAT clocks after the o_rd_req it answers.
- Stage 2 (t+2+RD_LAT):
  - o_de = (h < H_ACTIVE && v < V_ACTIVE).
  - o_hs active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - o_vs active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - o_rgb = captured data if the window flag is set; else BG_COLOR if o_de; else 0.
  - The window flag and o_de are carried through a shift register RD_LAT+1 deep.
- Total latency from counter to pins: L = RD_LAT+2, fixed and independent of SCALE_LOG2.
- Replication: each source pixel is requested on 2^SCALE_LOG2 consecutive clocks and 2^SCALE_LOG2 consecutive lines; addresses repeat.
- Arithmetic: all comparisons unsigned, CW bits wide; no intermediate overflow for CW=12 at defaults.
- Geometry constraint: the window must satisfy STARTCOL+(W<<SCALE_LOG2) <= H_ACTIVE and STARTROW+(H<<SCALE_LOG2) <= V_ACTIVE. Violation is a configuration error, flagged by an initial-block $error in simulation.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN
- With the macro:
  - Adds input i_pattern (1 bit).
  - While i_pattern = 1, o_rd_req is forced 0.
  - o_rgb in the active area shows 8 equal-width vertical colour bars: bar index = (h*8)/H_ACTIVE; colour = {index[2] replicated R, index[1] G, index[0] B} across the RGB565 fields.
  - Timing and latency are unchanged.
- Without the macro: the port and logic are absent; behaviour is as above.

Test Plan:
- Common bench geometry: H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=6, V_FP=1, V_SYNC=1, V_BP=1, RD_LAT=2.
- Idle/reset: i_state=0 for 100 clk -> counters 0, o_rd_req=0, o_hs=o_vs=1, o_rgb=0; async reset asserted mid-line -> all outputs reset immediately, without a clock edge.
- Timing: i_state=8'h03 -> hcnt wraps 11->0 with vcnt++, vcnt wraps 8->0; o_frame_start period 108 clk; o_hs low 2 clk per line, starting L=4 clk after hcnt=9; o_vs low for exactly 12 clk per frame.
- Window: W=5, H=4, STARTCOL=1, STARTROW=1, SCALE_LOG2=0 -> 20 o_rd_req cycles per frame; per line xpos sequence 0,1,2,3,4; ypos 0..3.
- Scaling: W=3, H=2, SCALE_LOG2=1 -> xpos sequence 0,0,1,1,2,2 on each of 4 lines; ypos 0,0,1,1; 24 requests per frame.
- Data path: SRAM model returns {ypos[7:0],xpos[7:0]} after RD_LAT -> o_rgb at window pixel (x,y) equals {y,x}, BG_COLOR elsewhere in the active area, 0 in blanking, all with o_de aligned.
- State drop: i_state -> 0 at hcnt=4, vcnt=2 -> next clk counters 0, o_rd_req=0, o_de=0; on return to 8'h03, o_frame_start pulses 1 clk after restart.

Source files
------------

// File: rtl/vga_frame_scanner_if.sv
// SRAM read port between the frame scanner and the pixel store.
// The master drives a read strobe plus source x/y address and receives pixel data a fixed number of clocks later.
// There is no backpressure: the store must answer every strobe after its fixed read latency.
interface vga_frame_scanner_if #(
  parameter int CW    = 12,
  parameter int PIX_W = 16
);
  logic             o_rd_req;
  logic [CW-1:0]    o_xpos;
  logic [CW-1:0]    o_ypos;
  logic [PIX_W-1:0] i_rd_data;

  modport master (output o_rd_req, output o_xpos, output o_ypos, input i_rd_data);
  modport slave  (input o_rd_req, input o_xpos, input o_ypos, output i_rd_data);
endinterface

// File: rtl/vga_frame_scanner.sv
// Configurable VGA timing generator that reads a scaled image window from SRAM and drives RGB/HS/DE/VS.
// Latency is RD_LAT+2 clocks from the counter to the pins; the SRAM address and strobe are registered one clock after the counter.
// No backpressure: scanning runs only while i_state == RUN_STATE, and otherwise everything is flushed to idle.
// Optional build macro VGA_TEST_PATTERN_EN adds i_pattern, which selects 8 vertical colour bars instead of SRAM data.
module vga_frame_scanner #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int W          = 320,
  parameter int H          = 240,
  parameter int STARTCOL   = 0,
  parameter int STARTROW   = 0,
  parameter int SCALE_LOG2 = 0,
  parameter int RD_LAT     = 2,
  parameter int PIX_W      = 16,
  parameter int CW         = 12,
  parameter logic [7:0]       RUN_STATE = 8'h03,
  parameter logic [PIX_W-1:0] BG_COLOR  = '0
) (
  input  logic             i_clk_sys,
  input  logic             i_rst_n,
  input  logic [7:0]       i_state,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             i_pattern,
`endif
  output logic [CW-1:0]    o_hcnt,
  output logic [CW-1:0]    o_vcnt,
  vga_frame_scanner_if.master sram,
  output logic             o_frame_start,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic [PIX_W-1:0] o_rgb
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LEN   = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LEN   = CW'(V_SYNC);
  localparam logic [CW-1:0] WIN_X0   = CW'(STARTCOL);
  localparam logic [CW-1:0] WIN_Y0   = CW'(STARTROW);
  localparam logic [CW-1:0] WIN_W    = CW'(W << SCALE_LOG2);
  localparam logic [CW-1:0] WIN_H    = CW'(H << SCALE_LOG2);
  localparam logic          SYNC_ACT = (SYNC_POL != 0);

  // Window must sit entirely inside the active area; the scaler and latency are bounded.
  if ((STARTCOL + (W << SCALE_LOG2) > H_ACTIVE) || (STARTROW + (H << SCALE_LOG2) > V_ACTIVE))
  begin : g_geom_err
    $error("vga_frame_scanner: image window exceeds the active area");
  end
  if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2 || RD_LAT < 1 || RD_LAT > 4) begin : g_param_err
    $error("vga_frame_scanner: SCALE_LOG2 or RD_LAT out of range");
  end

  logic run;
  assign run = (i_state == RUN_STATE);

  // Stage-1 state: counters double as o_hcnt/o_vcnt, plus the SRAM request.
  logic          run_q, run_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          rd_req_q, rd_req_d;
  logic [CW-1:0] xpos_q, xpos_d;
  logic [CW-1:0] ypos_q, ypos_d;
  logic          frame_start_q, frame_start_d;

  // Per-pixel flags delayed to line up with the SRAM data return.
  logic [RD_LAT:0] win_pipe_q, win_pipe_d;
  logic [RD_LAT:0] de_pipe_q, de_pipe_d;
  logic [RD_LAT:0] hs_pipe_q, hs_pipe_d;
  logic [RD_LAT:0] vs_pipe_q, vs_pipe_d;

  // Stage-2 pin registers.
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_q, de_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;

  logic [CW-1:0] x_rel, y_rel;
  logic          in_win, de_now, hs_now, vs_now;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CW+2:0] H_ACT_W = (CW+3)'(H_ACTIVE);
  logic [RD_LAT:0]      pat_pipe_q, pat_pipe_d;
  logic [RD_LAT:0][2:0] bar_pipe_q, bar_pipe_d;
  logic [CW+2:0]        bar_div;
  logic [2:0]           bar_idx;
  logic [15:0]          bar_rgb565;
`endif

  // Next counter position, window decode and the flag pipeline.
  always_comb begin
    run_d  = run;
    hcnt_d = '0;
    vcnt_d = '0;
    // The first running clock after idle lands on (0,0); later clocks advance.
    if (run && run_q) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
      end else begin
        hcnt_d = hcnt_q + CW'(1);
        vcnt_d = vcnt_q;
      end
    end

    // Offsets wrap to large values left of / above the window, so one compare covers both edges.
    x_rel  = hcnt_d - WIN_X0;
    y_rel  = vcnt_d - WIN_Y0;
    in_win = run && (x_rel < WIN_W) && (y_rel < WIN_H);
`ifdef VGA_TEST_PATTERN_EN
    if (i_pattern) in_win = 1'b0;
`endif
    de_now = run && (hcnt_d < H_ACT_C) && (vcnt_d < V_ACT_C);
    hs_now = run && ((hcnt_d - HS_START) < HS_LEN);
    vs_now = run && ((vcnt_d - VS_START) < VS_LEN);

    rd_req_d      = in_win;
    xpos_d        = in_win ? (x_rel >> SCALE_LOG2) : '0;
    ypos_d        = in_win ? (y_rel >> SCALE_LOG2) : '0;
    frame_start_d = run && (hcnt_d == '0) && (vcnt_d == '0);

    win_pipe_d = '0;
    de_pipe_d  = '0;
    hs_pipe_d  = '0;
    vs_pipe_d  = '0;
    if (run) begin
      win_pipe_d = {win_pipe_q[RD_LAT-1:0], in_win};
      de_pipe_d  = {de_pipe_q[RD_LAT-1:0], de_now};
      hs_pipe_d  = {hs_pipe_q[RD_LAT-1:0], hs_now};
      vs_pipe_d  = {vs_pipe_q[RD_LAT-1:0], vs_now};
    end

`ifdef VGA_TEST_PATTERN_EN
    bar_div    = ({3'b000, hcnt_d} << 3) / H_ACT_W;
    bar_idx    = bar_div[2:0];
    pat_pipe_d = '0;
    bar_pipe_d = '0;
    if (run) begin
      pat_pipe_d = {pat_pipe_q[RD_LAT-1:0], i_pattern};
      bar_pipe_d = {bar_pipe_q[RD_LAT-1:0], bar_idx};
    end
    bar_rgb565 = {{5{bar_pipe_q[RD_LAT][2]}}, {6{bar_pipe_q[RD_LAT][1]}}, {5{bar_pipe_q[RD_LAT][0]}}};
`endif
  end

  // Pin stage: choose SRAM data, background or blank, and drive the syncs.
  always_comb begin
    rgb_d = '0;
    if (run) begin
      if (win_pipe_q[RD_LAT]) begin
        rgb_d = sram.i_rd_data;
`ifdef VGA_TEST_PATTERN_EN
      end else if (de_pipe_q[RD_LAT] && pat_pipe_q[RD_LAT]) begin
        rgb_d = PIX_W'(bar_rgb565);
`endif
      end else if (de_pipe_q[RD_LAT]) begin
        rgb_d = BG_COLOR;
      end
    end
    de_d = run && de_pipe_q[RD_LAT];
    hs_d = (run && hs_pipe_q[RD_LAT]) ? SYNC_ACT : ~SYNC_ACT;
    vs_d = (run && vs_pipe_q[RD_LAT]) ? SYNC_ACT : ~SYNC_ACT;
  end

  // All state registers; reset leaves syncs at their inactive level.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q         <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      rd_req_q      <= 1'b0;
      xpos_q        <= '0;
      ypos_q        <= '0;
      frame_start_q <= 1'b0;
      win_pipe_q    <= '0;
      de_pipe_q     <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      hs_q          <= ~SYNC_ACT;
      vs_q          <= ~SYNC_ACT;
      de_q          <= 1'b0;
      rgb_q         <= '0;
`ifdef VGA_TEST_PATTERN_EN
      pat_pipe_q    <= '0;
      bar_pipe_q    <= '0;
`endif
    end else begin
      run_q         <= run_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      rd_req_q      <= rd_req_d;
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      frame_start_q <= frame_start_d;
      win_pipe_q    <= win_pipe_d;
      de_pipe_q     <= de_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
`ifdef VGA_TEST_PATTERN_EN
      pat_pipe_q    <= pat_pipe_d;
      bar_pipe_q    <= bar_pipe_d;
`endif
    end
  end

  assign o_hcnt        = hcnt_q;
  assign o_vcnt        = vcnt_q;
  assign sram.o_rd_req = rd_req_q;
  assign sram.o_xpos   = xpos_q;
  assign sram.o_ypos   = ypos_q;
  assign o_frame_start = frame_start_q;
  assign o_hs          = hs_q;
  assign o_vs          = vs_q;
  assign o_de          = de_q;
  assign o_rgb         = rgb_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner on a tiny 12x9 raster (8x6 active, RD_LAT=2).
// Two instances share clock/state: u_win (5x4 window at (1,1), unscaled) and u_scl (3x2 window, x2 scaling).
// Each DUT has an SRAM model that answers {ypos[7:0],xpos[7:0]} two clocks after the strobe.
module tb_vga_frame_scanner;
  localparam int CW    = 12;
  localparam int PIX_W = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] state = 8'h00;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  vga_frame_scanner_if #(.CW(CW), .PIX_W(PIX_W)) if_win ();
  vga_frame_scanner_if #(.CW(CW), .PIX_W(PIX_W)) if_scl ();

  logic [CW-1:0]    w_hcnt, w_vcnt, s_hcnt, s_vcnt;
  logic             w_fs, w_hs, w_vs, w_de, s_fs, s_hs, s_vs, s_de;
  logic [PIX_W-1:0] w_rgb, s_rgb;

  vga_frame_scanner #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .W(5), .H(4), .STARTCOL(1), .STARTROW(1), .SCALE_LOG2(0),
    .RD_LAT(2), .PIX_W(PIX_W), .CW(CW), .BG_COLOR(16'hBEEF)
  ) u_win (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_state(state),
`ifdef VGA_TEST_PATTERN_EN
    .i_pattern(1'b0),
`endif
    .o_hcnt(w_hcnt), .o_vcnt(w_vcnt), .sram(if_win),
    .o_frame_start(w_fs), .o_hs(w_hs), .o_vs(w_vs), .o_de(w_de), .o_rgb(w_rgb)
  );

  vga_frame_scanner #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .W(3), .H(2), .STARTCOL(0), .STARTROW(0), .SCALE_LOG2(1),
    .RD_LAT(2), .PIX_W(PIX_W), .CW(CW), .BG_COLOR(16'h00F0)
  ) u_scl (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_state(state),
`ifdef VGA_TEST_PATTERN_EN
    .i_pattern(1'b0),
`endif
    .o_hcnt(s_hcnt), .o_vcnt(s_vcnt), .sram(if_scl),
    .o_frame_start(s_fs), .o_hs(s_hs), .o_vs(s_vs), .o_de(s_de), .o_rgb(s_rgb)
  );

  // SRAM models: two-register read pipeline; non-requested slots return a poison value.
  logic [15:0] w_m1, w_m2, s_m1, s_m2;
  always @(posedge clk) begin
    w_m1 <= if_win.o_rd_req ? {if_win.o_ypos[7:0], if_win.o_xpos[7:0]} : 16'hDEAD;
    w_m2 <= w_m1;
    s_m1 <= if_scl.o_rd_req ? {if_scl.o_ypos[7:0], if_scl.o_xpos[7:0]} : 16'hDEAD;
    s_m2 <= s_m1;
  end
  assign if_win.i_rd_data = w_m2;
  assign if_scl.i_rd_data = s_m2;

  // Idle one clock, then enable; the next negedge observes restart cycle k=0 at (0,0).
  task automatic start_scan();
    @(negedge clk);
    state = 8'h00;
    @(negedge clk);
    state = 8'h03;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    state = 8'h00;
    repeat (5) @(negedge clk);
    checks++;
    if ({w_hcnt, w_vcnt, s_hcnt, s_vcnt} !== '0) begin
      errors++; $display("FAIL rst_cnt: got h=%0d v=%0d expected 0,0", w_hcnt, w_vcnt);
    end
    checks++;
    if ({w_hs, w_vs, s_hs, s_vs} !== 4'b1111) begin
      errors++; $display("FAIL rst_sync: got %b expected 1111", {w_hs, w_vs, s_hs, s_vs});
    end
    checks++;
    if ({w_rgb, s_rgb, w_de, s_de, w_fs, s_fs, if_win.o_rd_req, if_scl.o_rd_req} !== '0) begin
      errors++; $display("FAIL rst_out: got rgb=%h de=%b fs=%b req=%b expected all 0", w_rgb, w_de, w_fs, if_win.o_rd_req);
    end
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if ({w_hcnt, w_vcnt, if_win.o_rd_req, if_scl.o_rd_req} !== '0) begin
      errors++; $display("FAIL idle_cnt: got h=%0d v=%0d req=%b expected 0", w_hcnt, w_vcnt, if_win.o_rd_req);
    end
    checks++;
    if ({w_hs, w_vs} !== 2'b11 || w_rgb !== 16'h0000 || w_de !== 1'b0) begin
      errors++; $display("FAIL idle_out: got hs=%b vs=%b rgb=%h de=%b expected 1 1 0000 0", w_hs, w_vs, w_rgb, w_de);
    end
  endtask

  task automatic test_timing();
    int h, v, hd, vd, fs_cnt, hs_low, vs_low;
    logic ehs, evs;
    fs_cnt = 0; hs_low = 0; vs_low = 0;
    start_scan();
    for (int k = 0; k < 216; k++) begin
      @(negedge clk);
      h = k % 12;
      v = (k / 12) % 9;
      checks++;
      if (w_hcnt !== CW'(h) || w_vcnt !== CW'(v)) begin
        errors++; $display("FAIL cnt k=%0d: got (%0d,%0d) expected (%0d,%0d)", k, w_hcnt, w_vcnt, h, v);
      end
      checks++;
      if (w_fs !== (h == 0 && v == 0)) begin
        errors++; $display("FAIL frame_start k=%0d: got %b", k, w_fs);
      end
      ehs = 1'b1; evs = 1'b1;
      if (k >= 3) begin
        hd = (k - 3) % 12;
        vd = ((k - 3) / 12) % 9;
        ehs = !(hd >= 9 && hd < 11);
        evs = !(vd == 7);
      end
      checks++;
      if ({w_hs, w_vs, s_hs, s_vs} !== {ehs, evs, ehs, evs}) begin
        errors++; $display("FAIL sync k=%0d: got hs=%b vs=%b expected hs=%b vs=%b", k, w_hs, w_vs, ehs, evs);
      end
      fs_cnt += int'(w_fs);
      hs_low += int'(!w_hs);
      vs_low += int'(!w_vs);
    end
    checks++;
    if (fs_cnt != 2) begin errors++; $display("FAIL fs_count: got %0d expected 2", fs_cnt); end
    checks++;
    if (hs_low != 34) begin errors++; $display("FAIL hs_low_count: got %0d expected 34", hs_low); end
    checks++;
    if (vs_low != 24) begin errors++; $display("FAIL vs_low_count: got %0d expected 24", vs_low); end
  endtask

  task automatic test_window();
    int h, v, ex, ey, req;
    logic inw;
    req = 0;
    start_scan();
    for (int k = 0; k < 108; k++) begin
      @(negedge clk);
      h = k % 12;
      v = k / 12;
      inw = (h >= 1 && h <= 5 && v >= 1 && v <= 4);
      ex = inw ? h - 1 : 0;
      ey = inw ? v - 1 : 0;
      checks++;
      if (if_win.o_rd_req !== inw || if_win.o_xpos !== CW'(ex) || if_win.o_ypos !== CW'(ey)) begin
        errors++;
        $display("FAIL win_addr k=%0d: got req=%b x=%0d y=%0d expected req=%b x=%0d y=%0d",
                 k, if_win.o_rd_req, if_win.o_xpos, if_win.o_ypos, inw, ex, ey);
      end
      req += int'(if_win.o_rd_req);
    end
    checks++;
    if (req != 20) begin errors++; $display("FAIL win_req_count: got %0d expected 20", req); end
  endtask

  task automatic test_scaling();
    int h, v, ex, ey, req;
    logic inw;
    req = 0;
    start_scan();
    for (int k = 0; k < 108; k++) begin
      @(negedge clk);
      h = k % 12;
      v = k / 12;
      inw = (h < 6 && v < 4);
      ex = inw ? h / 2 : 0;
      ey = inw ? v / 2 : 0;
      checks++;
      if (if_scl.o_rd_req !== inw || if_scl.o_xpos !== CW'(ex) || if_scl.o_ypos !== CW'(ey)) begin
        errors++;
        $display("FAIL scl_addr k=%0d: got req=%b x=%0d y=%0d expected req=%b x=%0d y=%0d",
                 k, if_scl.o_rd_req, if_scl.o_xpos, if_scl.o_ypos, inw, ex, ey);
      end
      req += int'(if_scl.o_rd_req);
    end
    checks++;
    if (req != 24) begin errors++; $display("FAIL scl_req_count: got %0d expected 24", req); end
  endtask

  task automatic test_datapath();
    int hd, vd;
    logic ede;
    logic [15:0] ew, es;
    start_scan();
    for (int k = 0; k < 114; k++) begin
      @(negedge clk);
      ede = 1'b0; ew = 16'h0000; es = 16'h0000;
      if (k >= 3) begin
        hd = (k - 3) % 12;
        vd = ((k - 3) / 12) % 9;
        ede = (hd < 8 && vd < 6);
        if (hd >= 1 && hd <= 5 && vd >= 1 && vd <= 4) ew = {8'(vd - 1), 8'(hd - 1)};
        else if (ede) ew = 16'hBEEF;
        if (hd < 6 && vd < 4) es = {8'(vd / 2), 8'(hd / 2)};
        else if (ede) es = 16'h00F0;
      end
      checks++;
      if (w_de !== ede || w_rgb !== ew) begin
        errors++; $display("FAIL win_pix k=%0d: got de=%b rgb=%h expected de=%b rgb=%h", k, w_de, w_rgb, ede, ew);
      end
      checks++;
      if (s_de !== ede || s_rgb !== es) begin
        errors++; $display("FAIL scl_pix k=%0d: got de=%b rgb=%h expected de=%b rgb=%h", k, s_de, s_rgb, ede, es);
      end
    end
  endtask

  task automatic test_state_drop();
    logic found;
    found = 1'b0;
    start_scan();
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (w_hcnt == CW'(4) && w_vcnt == CW'(2)) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL drop_wait: got no (4,2) within 200 clk expected (4,2)"); end
    state = 8'h00;
    @(negedge clk);
    checks++;
    if ({w_hcnt, w_vcnt, s_hcnt, s_vcnt} !== '0) begin
      errors++; $display("FAIL drop_cnt: got (%0d,%0d) expected (0,0)", w_hcnt, w_vcnt);
    end
    checks++;
    if ({if_win.o_rd_req, if_scl.o_rd_req, w_fs, w_de, s_de} !== '0 || {w_hs, w_vs} !== 2'b11) begin
      errors++; $display("FAIL drop_ctl: got req=%b fs=%b de=%b hs=%b vs=%b expected 0 0 0 1 1",
                         if_win.o_rd_req, w_fs, w_de, w_hs, w_vs);
    end
    for (int n = 0; n < 4; n++) begin
      if (n > 0) @(negedge clk);
      checks++;
      if (w_rgb !== 16'h0000 || s_rgb !== 16'h0000 || w_de !== 1'b0) begin
        errors++; $display("FAIL drop_flush n=%0d: got rgb=%h/%h de=%b expected 0000 0", n, w_rgb, s_rgb, w_de);
      end
    end
    state = 8'h03;
    @(negedge clk);
    checks++;
    if (w_fs !== 1'b1 || w_hcnt !== CW'(0) || w_vcnt !== CW'(0)) begin
      errors++; $display("FAIL restart_fs: got fs=%b h=%0d v=%0d expected 1 0 0", w_fs, w_hcnt, w_vcnt);
    end
    @(negedge clk);
    checks++;
    if (w_fs !== 1'b0 || w_hcnt !== CW'(1)) begin
      errors++; $display("FAIL restart_next: got fs=%b h=%0d expected 0 1", w_fs, w_hcnt);
    end
  endtask

  task automatic test_async_reset();
    start_scan();
    repeat (30) @(negedge clk);
    checks++;
    if (w_rgb !== 16'h0101 || if_win.o_rd_req !== 1'b1) begin
      errors++; $display("FAIL pre_arst: got rgb=%h req=%b expected 0101 1", w_rgb, if_win.o_rd_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({w_hcnt, w_vcnt, if_win.o_rd_req, if_win.o_xpos, if_win.o_ypos} !== '0) begin
      errors++; $display("FAIL arst_addr: got h=%0d v=%0d req=%b x=%0d y=%0d expected all 0",
                         w_hcnt, w_vcnt, if_win.o_rd_req, if_win.o_xpos, if_win.o_ypos);
    end
    checks++;
    if ({w_hs, w_vs} !== 2'b11 || {w_de, w_fs} !== 2'b00 || w_rgb !== 16'h0000) begin
      errors++; $display("FAIL arst_pins: got hs=%b vs=%b de=%b rgb=%h expected 1 1 0 0000", w_hs, w_vs, w_de, w_rgb);
    end
    @(negedge clk);
    state = 8'h00;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_window();
    test_scaling();
    test_datapath();
    test_state_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
